// File: rtl/sdram_port_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_sched_if
//  Description : Bundle of the four toggle-handshake client ports and the
//                single toggle-handshake SDRAM controller port. The slave
//                modport is the scheduler's view; the master modport is the
//                surrounding logic (clients plus SDRAM controller).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_port_sched_if #(
  parameter int AW = 25,
  parameter int DW = 16
);
  // char client: read only
  logic          char_req;
  logic [AW-1:0] char_addr;
  logic          char_ack;
  logic [DW-1:0] char_dout;
  // download client: write only
  logic          dl_req;
  logic [AW-1:0] dl_addr;
  logic [DW-1:0] dl_din;
  logic          dl_ack;
  // rom client: read only
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic          rom_ack;
  logic [DW-1:0] rom_dout;
  // tape client: read only
  logic          tape_req;
  logic [AW-1:0] tape_addr;
  logic          tape_ack;
  logic [DW-1:0] tape_dout;
  // SDRAM controller side
  logic          mem_ready;
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  // status
  logic [3:0]    grant;
  logic          busy;

  modport slave (
    input  char_req, char_addr, dl_req, dl_addr, dl_din,
    input  rom_req, rom_addr, tape_req, tape_addr,
    input  mem_ready, mem_ack, mem_dout,
    output char_ack, char_dout, dl_ack, rom_ack, rom_dout, tape_ack, tape_dout,
    output mem_req, mem_addr, mem_din, mem_we, grant, busy
  );

  modport master (
    output char_req, char_addr, dl_req, dl_addr, dl_din,
    output rom_req, rom_addr, tape_req, tape_addr,
    output mem_ready, mem_ack, mem_dout,
    input  char_ack, char_dout, dl_ack, rom_ack, rom_dout, tape_ack, tape_dout,
    input  mem_req, mem_addr, mem_din, mem_we, grant, busy
  );
endinterface
`default_nettype wire

// File: rtl/sdram_port_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_sched
//  Description : Time-shares one toggle-handshake SDRAM port between the
//                char, dl, rom and tape clients. Fixed priority
//                char > dl > rom > tape, with a per-client age counter that
//                forces a client to the top once it has lost MAXAGE grants.
//                One transaction outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_sched #(
  parameter int AW     = 25,
  parameter int DW     = 16,
  parameter int MAXAGE = 3
) (
  input  logic              clk,
  input  logic              reset,
  sdram_port_sched_if.slave bus
);

  // Client index order matches the one-hot grant bit order {tape,rom,dl,char}
  localparam int c_char = 0;
  localparam int c_dl   = 1;
  localparam int c_rom  = 2;
  localparam int c_tape = 3;

  localparam int AGW = (MAXAGE < 2) ? 1 : $clog2(MAXAGE + 1);
  localparam logic [AGW-1:0] c_max_age = AGW'(MAXAGE);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_do_grant;
  logic           w_do_done;

  logic           r_mem_req;
  logic [AW-1:0]  r_mem_addr;
  logic [DW-1:0]  r_mem_din;
  logic           r_mem_we;
  logic [3:0]     r_grant;
  logic           r_busy;
  logic [3:0]     r_ack;
  logic [DW-1:0]  r_char_dout;
  logic [DW-1:0]  r_rom_dout;
  logic [DW-1:0]  r_tape_dout;
  logic [AGW-1:0] r_age [4];

  logic [3:0]     w_req;
  logic [3:0]     w_pend;
  logic [3:0]     w_starved;
  logic [3:0]     w_cand;
  logic [3:0]     w_win_oh;
  logic [1:0]     w_win_idx;
  logic [AW-1:0]  w_win_addr;

  assign w_req  = {bus.tape_req, bus.rom_req, bus.dl_req, bus.char_req};
  // A toggle request is outstanding while req and ack disagree
  assign w_pend = w_req ^ r_ack;

  // Flag pending clients whose age has reached the starvation limit
  always_comb begin
    w_starved = '0;
    for (int i = 0; i < 4; i++) begin
      w_starved[i] = w_pend[i] && (r_age[i] == c_max_age);
    end
  end

  // Pick the lowest-index candidate; starved clients pre-empt the plain order
  always_comb begin
    w_cand    = (|w_starved) ? w_starved : w_pend;
    w_win_oh  = '0;
    w_win_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
        w_win_idx   = 2'(i);
      end
    end
  end

  // Route the winner's address to the memory address register input
  always_comb begin
    w_win_addr = bus.char_addr;
    case (w_win_idx)
      2'd1:    w_win_addr = bus.dl_addr;
      2'd2:    w_win_addr = bus.rom_addr;
      2'd3:    w_win_addr = bus.tape_addr;
      default: w_win_addr = bus.char_addr;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and grant/complete strobes; completion never overlaps a grant
  always_comb begin
    w_state_nxt = r_state;
    w_do_grant  = 1'b0;
    w_do_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_ready && (|w_pend)) begin
          w_do_grant  = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // mem_ready is deliberately ignored here: an issued access must finish
        if (bus.mem_ack == r_mem_req) begin
          w_do_done   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: launch the winner's access, then return data and ack on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_mem_we    <= 1'b0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_ack       <= '0;
      r_char_dout <= '0;
      r_rom_dout  <= '0;
      r_tape_dout <= '0;
      for (int i = 0; i < 4; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      if (w_do_grant) begin
        r_mem_req  <= ~r_mem_req;
        r_mem_addr <= w_win_addr;
        if (w_win_oh[c_dl]) begin
          r_mem_din <= bus.dl_din;
        end
        r_mem_we <= w_win_oh[c_dl];
        r_grant  <= w_win_oh;
        r_busy   <= 1'b1;
        // Losers that are still waiting age (saturating); everyone else resets
        for (int i = 0; i < 4; i++) begin
          if (w_win_oh[i] || !w_pend[i]) begin
            r_age[i] <= '0;
          end else if (r_age[i] != c_max_age) begin
            r_age[i] <= r_age[i] + AGW'(1);
          end
        end
      end
      if (w_do_done) begin
        r_grant <= '0;
        r_busy  <= 1'b0;
        r_ack   <= r_ack ^ r_grant;
        if (!r_mem_we) begin
          if (r_grant[c_char]) r_char_dout <= bus.mem_dout;
          if (r_grant[c_rom])  r_rom_dout  <= bus.mem_dout;
          if (r_grant[c_tape]) r_tape_dout <= bus.mem_dout;
        end
      end
    end
  end

  assign bus.char_ack  = r_ack[c_char];
  assign bus.dl_ack    = r_ack[c_dl];
  assign bus.rom_ack   = r_ack[c_rom];
  assign bus.tape_ack  = r_ack[c_tape];
  assign bus.char_dout = r_char_dout;
  assign bus.rom_dout  = r_rom_dout;
  assign bus.tape_dout = r_tape_dout;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_din   = r_mem_din;
  assign bus.mem_we    = r_mem_we;
  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_port_sched
//  Description : Scoreboard bench for sdram_port_sched. Stimulus pushes the
//                hand-derived grant order and read data; a monitor pops and
//                compares on every mem_req toggle and every client ack toggle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_sched;

  typedef struct packed {
    logic [3:0]  grant;
    logic [24:0] addr;
    logic        we;
    logic [15:0] din;
  } gexp_t;

  typedef struct packed {
    logic [3:0]  who;
    logic [15:0] dout;
  } dexp_t;

  logic  clk;
  logic  reset;
  int    n_checks;
  int    n_pass;
  gexp_t gq[$];
  dexp_t dq[$];

  // memory model controls
  bit          auto_ack;
  int          lat;
  bit          ovr_en;
  logic [15:0] ovr;

  sdram_port_sched_if #(.AW(25), .DW(16)) bus ();

  sdram_port_sched #(.AW(25), .DW(16), .MAXAGE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  function automatic logic [15:0] f_rd(input logic [24:0] a);
    return a[15:0] ^ 16'h3C3C;
  endfunction

  function automatic logic [3:0] reqs_v();
    return {bus.tape_req, bus.rom_req, bus.dl_req, bus.char_req};
  endfunction

  function automatic logic [3:0] acks_v();
    return {bus.tape_ack, bus.rom_ack, bus.dl_ack, bus.char_ack};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_grant(input int c);
    gexp_t g;
    g.grant = 4'(1 << c);
    case (c)
      0:       g.addr = bus.char_addr;
      1:       g.addr = bus.dl_addr;
      2:       g.addr = bus.rom_addr;
      default: g.addr = bus.tape_addr;
    endcase
    g.we  = (c == 1);
    g.din = bus.dl_din;
    gq.push_back(g);
  endtask

  task automatic expect_done(input int c, input logic [15:0] data);
    dexp_t d;
    d.who  = 4'(1 << c);
    d.dout = data;
    dq.push_back(d);
  endtask

  task automatic expect_txn(input int c);
    logic [24:0] a;
    expect_grant(c);
    case (c)
      0:       a = bus.char_addr;
      1:       a = bus.dl_addr;
      2:       a = bus.rom_addr;
      default: a = bus.tape_addr;
    endcase
    expect_done(c, f_rd(a));
  endtask

  task automatic reset_dut(input bit do_check);
    reset = 1'b1;
    bus.char_req = 1'b0;
    bus.dl_req   = 1'b0;
    bus.rom_req  = 1'b0;
    bus.tape_req = 1'b0;
    @(posedge clk); #1;
    if (do_check) begin
      check("rst_acks", acks_v(), 4'b0000);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_grant", bus.grant, 4'b0000);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_mem_bus", {bus.mem_addr, bus.mem_din, bus.mem_we}, 42'd0);
      check("rst_douts", {bus.char_dout, bus.rom_dout, bus.tape_dout}, 48'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!bus.busy && (reqs_v() == acks_v())) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s: timeout, got busy=%0b reqs=%h acks=%h expected idle",
               name, bus.busy, reqs_v(), acks_v());
    end
    @(negedge clk);
  endtask

  // SDRAM controller model: acks lat cycles after seeing an outstanding request
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ack  = 1'b0;
    bus.mem_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end else if (auto_ack && (bus.mem_req != bus.mem_ack)) begin
        if (cnt >= lat) begin
          bus.mem_dout = ovr_en ? ovr : f_rd(bus.mem_addr);
          bus.mem_ack  = bus.mem_req;
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: pop and compare on each new grant and each client completion
  initial begin
    logic        p_req;
    logic [3:0]  p_ack;
    logic [3:0]  ack_now;
    logic [3:0]  tg;
    logic [15:0] rd;
    gexp_t       g;
    dexp_t       d;
    p_req = 1'b0;
    p_ack = '0;
    forever begin
      @(negedge clk);
      ack_now = acks_v();
      if (!reset) begin
        if (bus.mem_req !== p_req) begin
          if (gq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_grant: got grant=%b addr=0x%0h expected none",
                     bus.grant, bus.mem_addr);
          end else begin
            g = gq.pop_front();
            check("grant", bus.grant, g.grant);
            check("mem_addr", bus.mem_addr, g.addr);
            check("mem_we", bus.mem_we, g.we);
            if (g.we) check("mem_din", bus.mem_din, g.din);
            check("busy_on_grant", bus.busy, 1'b1);
          end
        end
        tg = ack_now ^ p_ack;
        if (tg != 4'b0000) begin
          if (dq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_ack: got toggled=%b expected none", tg);
          end else begin
            d = dq.pop_front();
            check("ack_client", tg, d.who);
            case (d.who)
              4'b0001: rd = bus.char_dout;
              4'b0100: rd = bus.rom_dout;
              4'b1000: rd = bus.tape_dout;
              default: rd = '0;
            endcase
            if (d.who != 4'b0010) check("client_dout", rd, d.dout);
            check("busy_after_done", bus.busy, 1'b0);
          end
        end
      end
      p_req = bus.mem_req;
      p_ack = ack_now;
    end
  end

  // Directed stimulus
  initial begin
    logic prev_req;
    bit   held_ok;
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    auto_ack      = 1'b1;
    lat           = 0;
    ovr_en        = 1'b0;
    ovr           = '0;
    bus.mem_ready = 1'b0;
    bus.char_req  = 1'b0;
    bus.dl_req    = 1'b0;
    bus.rom_req   = 1'b0;
    bus.tape_req  = 1'b0;
    bus.char_addr = 25'h0001234;
    bus.dl_addr   = 25'h1000010;
    bus.dl_din    = 16'hBEEF;
    bus.rom_addr  = 25'h000F000;
    bus.tape_addr = 25'h0030000;

    // 1: reset state, then a single rom read with data 0xA55A
    reset_dut(1'b1);
    bus.mem_ready = 1'b1;
    ovr_en = 1'b1;
    ovr    = 16'hA55A;
    bus.rom_req = ~bus.rom_req;
    expect_grant(2);
    expect_done(2, 16'hA55A);
    @(posedge clk); #1;
    check("t1_mem_req_1clk", bus.mem_req, 1'b1);
    check("t1_mem_addr", bus.mem_addr, 25'h000F000);
    check("t1_grant", bus.grant, 4'b0100);
    @(posedge clk); #1;
    check("t1_rom_dout", bus.rom_dout, 16'hA55A);
    check("t1_rom_ack", bus.rom_ack, 1'b1);
    check("t1_busy", bus.busy, 1'b0);
    wait_idle("t1_idle");
    ovr_en = 1'b0;

    // 2: all four toggle together -> char, dl, rom, tape
    bus.rom_addr = 25'h0002000;
    reset_dut(1'b0);
    bus.mem_ready = 1'b1;
    expect_txn(0);
    expect_txn(1);
    expect_txn(2);
    expect_txn(3);
    bus.char_req = ~bus.char_req;
    bus.dl_req   = ~bus.dl_req;
    bus.rom_req  = ~bus.rom_req;
    bus.tape_req = ~bus.tape_req;
    wait_idle("t2_idle");
    check("t2_acks_eq_reqs", acks_v(), reqs_v());

    // 3: char and rom keep re-requesting while tape waits -> tape on 4th grant
    reset_dut(1'b0);
    expect_txn(0);
    expect_txn(0);
    expect_txn(0);
    expect_txn(2);
    expect_txn(3);
    expect_txn(0);
    expect_txn(2);
    bus.char_req = ~bus.char_req;
    bus.rom_req  = ~bus.rom_req;
    @(posedge clk); #1;
    bus.tape_req = ~bus.tape_req;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(posedge clk); #1;
        if (bus.tape_req != bus.tape_ack) begin
          if (bus.char_req == bus.char_ack) bus.char_req = ~bus.char_req;
          if (bus.rom_req == bus.rom_ack)   bus.rom_req  = ~bus.rom_req;
        end else if (!bus.busy && (reqs_v() == acks_v())) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        n_checks++;
        $display("FAIL t3_ageing: timeout, got reqs=%h acks=%h expected idle",
                 reqs_v(), acks_v());
      end
      @(negedge clk);
    end
    check("t3_acks_eq_reqs", acks_v(), reqs_v());

    // 4: mem_ready low blocks the grant; raising it grants 1 clk later
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    prev_req = bus.mem_req;
    bus.dl_din = 16'h1357;
    bus.dl_req = ~bus.dl_req;
    repeat (8) @(posedge clk);
    #1;
    check("t4_no_mem_req", bus.mem_req, prev_req);
    check("t4_not_busy", bus.busy, 1'b0);
    expect_txn(1);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_busy_after_ready", bus.busy, 1'b1);
    check("t4_grant_dl", bus.grant, 4'b0010);
    wait_idle("t4_idle");

    // 5: slow controller; mem_ready dips mid-wait; queued clients follow in order
    lat = 20;
    expect_txn(3);
    bus.tape_req = ~bus.tape_req;
    @(posedge clk); #1;
    expect_txn(0);
    expect_txn(1);
    bus.char_req = ~bus.char_req;
    bus.dl_req   = ~bus.dl_req;
    held_ok = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if ((bus.busy !== 1'b1) || (bus.grant !== 4'b1000)) held_ok = 1'b0;
      if (i == 4)  bus.mem_ready = 1'b0;
      if (i == 12) bus.mem_ready = 1'b1;
    end
    check("t5_held_tape_busy", held_ok, 1'b1);
    wait_idle("t5_idle");
    lat = 0;

    // 6: reset while waiting abandons the access; a fresh rom read then works
    auto_ack = 1'b0;
    expect_grant(2);
    bus.rom_req = ~bus.rom_req;
    @(posedge clk); #1;
    check("t6_busy_pre_reset", bus.busy, 1'b1);
    @(posedge clk); #1;
    reset_dut(1'b1);
    auto_ack = 1'b1;
    bus.mem_ready = 1'b1;
    expect_txn(2);
    bus.rom_req = ~bus.rom_req;
    wait_idle("t6_idle");
    check("t6_rom_ack", bus.rom_ack, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("grant_queue_empty", gq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
